// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stage-control unit for the 5-stage pipeline: RAW/branch detection,
// stage enables/flushes, operand-bypass selects and saturating stall counters.
module pipeline_hazard_ctrl #(
   parameter int ADDR_W     = 5,
   parameter int FORWARD    = 1,
   parameter int BR_RESOLVE = 3,
   parameter int ZERO_REG   = 1,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [ADDR_W-1:0] id_rs_addr,
   input  logic [ADDR_W-1:0] id_rt_addr,
   input  logic              id_rs_used,
   input  logic              id_rt_used,
   input  logic              id_wr_en,
   input  logic [ADDR_W-1:0] id_wr_addr,
   input  logic              id_is_load,
   input  logic              id_is_branch,
   output logic              if_en,
   output logic              id_en,
   output logic              exe_en,
   output logic              mem_en,
   output logic              wb_en,
   output logic              id_rst,
   output logic              exe_rst,
   output logic              data_stall,
   output logic              branch_stall,
   output logic [1:0]        fwd_a_sel,
   output logic [1:0]        fwd_b_sel,
   output logic [CNT_W-1:0]  data_stall_cnt,
   output logic [CNT_W-1:0]  branch_stall_cnt,
   output logic              br_state
);

   typedef struct packed {
      logic              valid;
      logic              wr_en;
      logic [ADDR_W-1:0] addr;
      logic              is_load;
   } sb_t;

   typedef enum logic {IDLE, WAIT} br_state_t;

   localparam logic [1:0] BR_INIT = 2'(BR_RESOLVE);

   sb_t       exe_q, mem_q, wb_q;
   br_state_t state_q, state_d;
   logic [1:0] cnt_q, cnt_d;

   logic id_live, in_wait, raw_stall, any_hit, load_use;
   logic rs_exe, rs_mem, rs_wb, rt_exe, rt_mem, rt_wb;

   function automatic logic src_hit(input logic used, input logic [ADDR_W-1:0] a,
                                    input sb_t e, input logic live);
      return used && live && e.valid && e.wr_en && (e.addr == a) &&
             !((ZERO_REG != 0) && (a == '0));
   endfunction

   // Youngest producer wins: EXE, then MEM, then WB.
   function automatic logic [1:0] pick(input logic h_exe, input logic h_mem, input logic h_wb);
      if (h_exe)      return 2'b01;
      else if (h_mem) return 2'b10;
      else if (h_wb)  return 2'b11;
      else            return 2'b00;
   endfunction

   always_comb begin
      in_wait  = (state_q == WAIT);
      id_live  = id_valid && !in_wait;
      rs_exe   = src_hit(id_rs_used, id_rs_addr, exe_q, id_live);
      rs_mem   = src_hit(id_rs_used, id_rs_addr, mem_q, id_live);
      rs_wb    = src_hit(id_rs_used, id_rs_addr, wb_q,  id_live);
      rt_exe   = src_hit(id_rt_used, id_rt_addr, exe_q, id_live);
      rt_mem   = src_hit(id_rt_used, id_rt_addr, mem_q, id_live);
      rt_wb    = src_hit(id_rt_used, id_rt_addr, wb_q,  id_live);
      any_hit  = rs_exe || rs_mem || rs_wb || rt_exe || rt_mem || rt_wb;
      load_use = (rs_exe || rt_exe) && exe_q.is_load;
      raw_stall = (FORWARD != 0) ? load_use : any_hit;

      data_stall   = rst && raw_stall;
      branch_stall = rst && in_wait;
      fwd_a_sel    = 2'b00;
      fwd_b_sel    = 2'b00;
      if ((FORWARD != 0) && rst && !raw_stall) begin
         fwd_a_sel = pick(rs_exe, rs_mem, rs_wb);
         fwd_b_sel = pick(rt_exe, rt_mem, rt_wb);
      end
   end

   always_comb begin
      if_en   = 1'b1;
      id_en   = 1'b1;
      exe_en  = 1'b1;
      mem_en  = 1'b1;
      wb_en   = 1'b1;
      id_rst  = 1'b0;
      exe_rst = 1'b0;
      if (!rst) begin
         if_en   = 1'b0;
         id_en   = 1'b0;
         exe_en  = 1'b0;
         mem_en  = 1'b0;
         wb_en   = 1'b0;
         id_rst  = 1'b1;
         exe_rst = 1'b1;
      end else if (in_wait) begin
         // IF is released on the last wait cycle so the PC takes the resolved target.
         if_en   = (cnt_q == 2'd1);
         id_rst  = 1'b1;
         exe_rst = 1'b1;
      end else if (raw_stall) begin
         if_en   = 1'b0;
         id_en   = 1'b0;
         exe_rst = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (id_live && id_is_branch && !raw_stall) begin
               state_d = WAIT;
               cnt_d   = BR_INIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 2'd1;
            if (cnt_q == 2'd1) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign br_state = (state_q == WAIT);

   always_ff @(posedge clk) begin
      if (!rst) begin
         exe_q            <= '0;
         mem_q            <= '0;
         wb_q             <= '0;
         state_q          <= IDLE;
         cnt_q            <= '0;
         data_stall_cnt   <= '0;
         branch_stall_cnt <= '0;
      end else begin
         wb_q  <= mem_q;
         mem_q <= exe_q;
         if (data_stall || branch_stall)
            exe_q <= '0;
         else
            exe_q <= '{valid: id_valid, wr_en: id_wr_en, addr: id_wr_addr, is_load: id_is_load};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (data_stall && (data_stall_cnt != '1))
            data_stall_cnt <= data_stall_cnt + 1'b1;
         if (branch_stall && (branch_stall_cnt != '1))
            branch_stall_cnt <= branch_stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: a stall-only instance (BR_RESOLVE=2, 4-bit counters)
// and a forwarding instance (BR_RESOLVE=3) share stimulus and are checked against a model.
module tb_pipeline_hazard_ctrl;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       id_valid, id_rs_used, id_rt_used, id_wr_en, id_is_load, id_is_branch;
   logic [4:0] id_rs_addr, id_rt_addr, id_wr_addr;

   logic [1:0] if_en, id_en, exe_en, mem_en, wb_en, id_rst, exe_rst;
   logic [1:0] dstall, bstall, br_state;
   logic [1:0] fa0, fb0, fa1, fb1;
   logic [3:0] dcnt0, bcnt0;
   logic [15:0] dcnt1, bcnt1;

   pipeline_hazard_ctrl #(.ADDR_W(5), .FORWARD(0), .BR_RESOLVE(2), .ZERO_REG(1), .CNT_W(4)) dut_s (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
      .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr),
      .id_is_load(id_is_load), .id_is_branch(id_is_branch),
      .if_en(if_en[0]), .id_en(id_en[0]), .exe_en(exe_en[0]), .mem_en(mem_en[0]), .wb_en(wb_en[0]),
      .id_rst(id_rst[0]), .exe_rst(exe_rst[0]),
      .data_stall(dstall[0]), .branch_stall(bstall[0]),
      .fwd_a_sel(fa0), .fwd_b_sel(fb0),
      .data_stall_cnt(dcnt0), .branch_stall_cnt(bcnt0), .br_state(br_state[0])
   );

   pipeline_hazard_ctrl #(.ADDR_W(5), .FORWARD(1), .BR_RESOLVE(3), .ZERO_REG(1), .CNT_W(16)) dut_f (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
      .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr),
      .id_is_load(id_is_load), .id_is_branch(id_is_branch),
      .if_en(if_en[1]), .id_en(id_en[1]), .exe_en(exe_en[1]), .mem_en(mem_en[1]), .wb_en(wb_en[1]),
      .id_rst(id_rst[1]), .exe_rst(exe_rst[1]),
      .data_stall(dstall[1]), .branch_stall(bstall[1]),
      .fwd_a_sel(fa1), .fwd_b_sel(fb1),
      .data_stall_cnt(dcnt1), .branch_stall_cnt(bcnt1), .br_state(br_state[1])
   );

   // ---------------- scoreboard / checker ----------------
   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Per instance: the last three instructions that entered EXE (index 0 = newest),
   // remaining branch-wait cycles, and the stall counts.
   typedef struct packed {
      logic       v;
      logic       w;
      logic [4:0] a;
      logic       ld;
   } ent_t;

   ent_t hist [2][3];
   int   br_left [2];
   int   dc [2];
   int   bc [2];

   function automatic logic src_match(input ent_t e, input logic [4:0] a);
      return e.v && e.w && (e.a == a) && (a != 5'd0);
   endfunction

   task automatic model_step(input int m);
      logic waiting, live, ds, bs, any_h, ld_use, ha, hb;
      logic e_if, e_id, e_exe, e_mem, e_wb, e_idr, e_exr;
      logic [1:0] efa, efb, gfa, gfb;
      logic [15:0] gdc, gbc;
      int sa, sb, brr, cmax;
      string p;
      brr  = (m == 0) ? 2 : 3;
      cmax = (m == 0) ? 15 : 65535;
      p    = $sformatf("m%0d_", m);
      waiting = (br_left[m] > 0);
      live    = id_valid && !waiting;
      any_h = 1'b0; ld_use = 1'b0; sa = 0; sb = 0;
      for (int k = 0; k < 3; k++) begin
         ha = live && id_rs_used && src_match(hist[m][k], id_rs_addr);
         hb = live && id_rt_used && src_match(hist[m][k], id_rt_addr);
         if (ha || hb) begin
            any_h = 1'b1;
            if (k == 0 && hist[m][k].ld) ld_use = 1'b1;
         end
         if (ha && sa == 0) sa = k + 1;
         if (hb && sb == 0) sb = k + 1;
      end
      ds  = rst && ((m == 1) ? ld_use : any_h);
      bs  = rst && waiting;
      efa = (m == 1 && rst && !ds) ? 2'(sa) : 2'b00;
      efb = (m == 1 && rst && !ds) ? 2'(sb) : 2'b00;
      if (!rst) begin
         {e_if, e_id, e_exe, e_mem, e_wb} = 5'b00000; e_idr = 1'b1; e_exr = 1'b1;
      end else if (waiting) begin
         e_if = (br_left[m] == 1); {e_id, e_exe, e_mem, e_wb} = 4'b1111; e_idr = 1'b1; e_exr = 1'b1;
      end else if (ds) begin
         {e_if, e_id, e_exe, e_mem, e_wb} = 5'b00111; e_idr = 1'b0; e_exr = 1'b1;
      end else begin
         {e_if, e_id, e_exe, e_mem, e_wb} = 5'b11111; e_idr = 1'b0; e_exr = 1'b0;
      end
      gfa = (m == 0) ? fa0 : fa1;
      gfb = (m == 0) ? fb0 : fb1;
      gdc = (m == 0) ? {12'd0, dcnt0} : dcnt1;
      gbc = (m == 0) ? {12'd0, bcnt0} : bcnt1;

      check({p, "if_en"},   16'(if_en[m]),   16'(e_if));
      if (!(rst && waiting)) begin
         check({p, "id_en"},  16'(id_en[m]),  16'(e_id));
         check({p, "exe_en"}, 16'(exe_en[m]), 16'(e_exe));
      end
      check({p, "mem_en"},  16'(mem_en[m]),  16'(e_mem));
      check({p, "wb_en"},   16'(wb_en[m]),   16'(e_wb));
      check({p, "id_rst"},  16'(id_rst[m]),  16'(e_idr));
      check({p, "exe_rst"}, 16'(exe_rst[m]), 16'(e_exr));
      check({p, "data_stall"},   16'(dstall[m]), 16'(ds));
      check({p, "branch_stall"}, 16'(bstall[m]), 16'(bs));
      check({p, "fwd_a"}, 16'(gfa), 16'(efa));
      check({p, "fwd_b"}, 16'(gfb), 16'(efb));
      check({p, "dcnt"},  gdc, 16'(dc[m]));
      check({p, "bcnt"},  gbc, 16'(bc[m]));
      check({p, "br_state"}, 16'(br_state[m]), 16'(waiting));

      if (!rst) begin
         for (int k = 0; k < 3; k++) hist[m][k] = '0;
         br_left[m] = 0; dc[m] = 0; bc[m] = 0;
      end else begin
         if (ds && dc[m] < cmax) dc[m]++;
         if (bs && bc[m] < cmax) bc[m]++;
         hist[m][2] = hist[m][1];
         hist[m][1] = hist[m][0];
         hist[m][0] = (ds || bs) ? ent_t'(0) : ent_t'{id_valid, id_wr_en, id_wr_addr, id_is_load};
         if (waiting) br_left[m]--;
         else if (live && id_is_branch && !ds) br_left[m] = brr;
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step(input logic r, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic ru, input logic tu, input logic we, input logic [4:0] wa,
                       input logic ld, input logic br);
      @(negedge clk);
      rst = r; id_valid = v; id_rs_addr = rs; id_rt_addr = rt;
      id_rs_used = ru; id_rt_used = tu; id_wr_en = we; id_wr_addr = wa;
      id_is_load = ld; id_is_branch = br;
      #1;
      model_step(0);
      model_step(1);
   endtask

   task automatic nop();
      step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++)
         step(1'b0, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b0; id_valid = 1'b0; id_rs_addr = '0; id_rt_addr = '0;
      id_rs_used = 1'b0; id_rt_used = 1'b0; id_wr_en = 1'b0; id_wr_addr = '0;
      id_is_load = 1'b0; id_is_branch = 1'b0;
      for (int m = 0; m < 2; m++) begin
         for (int k = 0; k < 3; k++) hist[m][k] = '0;
         br_left[m] = 0; dc[m] = 0; bc[m] = 0;
      end
      repeat (2) @(posedge clk);

      // reset hold with a live ID, then release
      do_reset(3);
      check("rst_if_en", 16'(if_en[1]), 16'd0);
      check("rst_id_rst", 16'(id_rst[1]), 16'd1);
      check("rst_dstall", 16'(dstall[1]), 16'd0);
      check("rst_dcnt", dcnt1, 16'd0);
      nop();
      check("post_rst_en", 16'({if_en[1], id_en[1], exe_en[1], mem_en[1], wb_en[1]}), 16'h1f);
      check("post_rst_en_s", 16'({if_en[0], id_en[0], exe_en[0], mem_en[0], wb_en[0]}), 16'h1f);
      check("post_rst_rst", 16'({id_rst[1], exe_rst[1]}), 16'd0);

      // add $3,$1,$2 then two readers of $3
      do_reset(1);
      step(1, 1, 5'd1, 5'd2, 1, 1, 1, 5'd3, 0, 0);
      step(1, 1, 5'd3, 5'd0, 1, 0, 1, 5'd7, 0, 0);
      check("fwd_exe", 16'(fa1), 16'd1);
      check("fwd_exe_nostall", 16'(dstall[1]), 16'd0);
      step(1, 1, 5'd3, 5'd0, 1, 0, 0, 5'd0, 0, 0);
      check("fwd_mem", 16'(fa1), 16'd2);

      // load-use on rt
      do_reset(1);
      step(1, 1, 5'd1, 5'd0, 1, 0, 1, 5'd5, 1, 0);
      step(1, 1, 5'd2, 5'd5, 1, 1, 1, 5'd8, 0, 0);
      check("lu_stall", 16'(dstall[1]), 16'd1);
      check("lu_exe_rst", 16'(exe_rst[1]), 16'd1);
      step(1, 1, 5'd2, 5'd5, 1, 1, 1, 5'd8, 0, 0);
      check("lu_release", 16'(dstall[1]), 16'd0);
      check("lu_fwd_b", 16'(fb1), 16'd2);
      check("lu_cnt", dcnt1, 16'd1);

      // stall-only: three bubbles behind a producer of $4
      do_reset(1);
      step(1, 1, 5'd1, 5'd2, 1, 1, 1, 5'd4, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(1, 1, 5'd4, 5'd0, 1, 0, 0, 5'd0, 0, 0);
         check("so_stall", 16'(dstall[0]), 16'd1);
      end
      step(1, 1, 5'd4, 5'd0, 1, 0, 0, 5'd0, 0, 0);
      check("so_release", 16'(dstall[0]), 16'd0);
      check("so_fwd", 16'(fa0), 16'd0);
      check("so_cnt", 16'(dcnt0), 16'd3);

      // $0 destination never stalls
      do_reset(1);
      step(1, 1, 5'd1, 5'd2, 1, 1, 1, 5'd0, 1, 0);
      step(1, 1, 5'd0, 5'd0, 1, 1, 0, 5'd0, 0, 0);
      check("zero_s", 16'(dstall[0]), 16'd0);
      check("zero_f", 16'(dstall[1]), 16'd0);

      // branch, with a second branch held in ID
      do_reset(1);
      step(1, 1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1);
      check("br_accept", 16'(bstall[1]), 16'd0);
      for (int i = 0; i < 3; i++) begin
         step(1, 1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1);
         check("br_wait", 16'(bstall[1]), 16'd1);
         check("br_if_en", 16'(if_en[1]), (i == 2) ? 16'd1 : 16'd0);
      end
      step(1, 1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1);
      check("br_idle", 16'(bstall[1]), 16'd0);
      check("br_cnt", bcnt1, 16'd3);
      step(1, 1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1);
      check("br_second", 16'(bstall[1]), 16'd1);

      // branch behind a load-use, then reset mid-wait
      do_reset(1);
      step(1, 1, 5'd1, 5'd0, 1, 0, 1, 5'd6, 1, 0);
      step(1, 1, 5'd6, 5'd0, 1, 0, 0, 5'd0, 0, 1);
      check("brlu_dstall", 16'(dstall[1]), 16'd1);
      check("brlu_bstall", 16'(bstall[1]), 16'd0);
      step(1, 1, 5'd6, 5'd0, 1, 0, 0, 5'd0, 0, 1);
      check("brlu_clean", 16'(dstall[1]), 16'd0);
      check("brlu_fwd", 16'(fa1), 16'd2);
      step(1, 1, 5'd6, 5'd0, 1, 0, 0, 5'd0, 0, 1);
      check("brlu_wait", 16'(bstall[1]), 16'd1);
      step(0, 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0);
      nop();
      check("brlu_rst_idle", 16'(br_state[1]), 16'd0);
      check("brlu_rst_bstall", 16'(bstall[1]), 16'd0);

      // 4-bit counter saturation in the stall-only instance
      do_reset(1);
      for (int i = 0; i < 8; i++) begin
         step(1, 1, 5'd1, 5'd2, 1, 1, 1, 5'd9, 0, 0);
         repeat (4) step(1, 1, 5'd9, 5'd0, 1, 0, 0, 5'd0, 0, 0);
      end
      check("sat_cnt", 16'(dcnt0), 16'hf);

      // randomized traffic
      do_reset(1);
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0,
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)),
              $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
